arm_dmem_responder: RTL and testbench

//  Responder for the pipelined ARM core's data-memory port. It serves the core's

---
 rtl/arm_dmem_pkg.sv | 23 ++
 rtl/arm_tx_fifo.sv | 50 +++++
 rtl/arm_dmem_responder.sv | 147 ++++++++++++++
 tb/tb_arm_dmem_responder.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_dmem_pkg.sv
// Shared MMIO offsets, register bit positions and address-region type for the
// ARM data-memory responder.
package arm_dmem_pkg;

    localparam logic [7:0] OFF_CYCLE  = 8'h00;
    localparam logic [7:0] OFF_TCMP   = 8'h04;
    localparam logic [7:0] OFF_TSTAT  = 8'h08;
    localparam logic [7:0] OFF_TXDATA = 8'h0C;
    localparam logic [7:0] OFF_TXSTAT = 8'h10;

    localparam int TSTAT_MATCH  = 0;
    localparam int TSTAT_EN     = 1;
    localparam int TXSTAT_FULL  = 0;
    localparam int TXSTAT_EMPTY = 1;
    localparam int TXSTAT_OVF   = 2;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_MMIO,
        REG_NONE
    } region_e;

endpackage

// File: rtl/arm_tx_fifo.sv
// Synchronous byte FIFO for the TX path: registered occupancy, head visible on
// dout while non-empty, zero while empty.
module arm_tx_fifo #(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         push,
    input  logic [7:0]                   din,
    input  logic                         pop,
    output logic [7:0]                   dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(FIFO_DEPTH):0]  count
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          pop_ok;
    logic          accept;

    assign full   = (count == CW'(FIFO_DEPTH));
    assign empty  = (count == '0);
    assign pop_ok = pop && !empty;
    // A full FIFO still takes a byte when the head leaves on the same edge.
    assign accept = push && (!full || pop_ok);

    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok) rd_ptr <= rd_ptr + PW'(1);
            if (accept && !pop_ok)      count <= count + CW'(1);
            else if (pop_ok && !accept) count <= count - CW'(1);
        end
    end

    assign dout = empty ? 8'h00 : mem[rd_ptr];

endmodule

// File: rtl/arm_dmem_responder.sv
// Data-memory responder: word RAM, cycle counter, compare timer and TX FIFO.
// Define ARM_DMEM_TIMER_EN to build the TCMP/TSTAT timer and irq.
module arm_dmem_responder
    import arm_dmem_pkg::*;
#(
    parameter int unsigned RAM_WORDS  = 64,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        MemWriteM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        irq
);
    localparam int          AW        = $clog2(RAM_WORDS);
    localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

    region_e       region;
    logic [7:0]    offset;
    logic [AW-1:0] ram_idx;
    logic          mmio_wr;
    logic [31:0]   ram [RAM_WORDS];
    logic [31:0]   cycle;
    logic [31:0]   tcmp_rd;
    logic [31:0]   tstat_rd;
    logic [31:0]   txstat;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          ovf;

    always_comb begin
        if (ALUOutM < RAM_BYTES)                     region = REG_RAM;
        else if (ALUOutM[31:16] == MMIO_BASE[31:16]) region = REG_MMIO;
        else                                         region = REG_NONE;
    end

    assign offset  = ALUOutM[7:0];
    assign ram_idx = ALUOutM[AW+1:2];
    assign mmio_wr = MemWriteM && (region == REG_MMIO);

    // RAM contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (MemWriteM && (region == REG_RAM)) ram[ram_idx] <= WriteDataM;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cycle <= '0;
        else          cycle <= cycle + 32'd1;
    end

`ifdef ARM_DMEM_TIMER_EN
    logic [31:0] tcmp;
    logic        match;
    logic        en;

    // A compare hit on the same edge as a MATCH clear keeps MATCH set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tcmp  <= '0;
            match <= 1'b0;
            en    <= 1'b0;
        end else begin
            if (mmio_wr && offset == OFF_TCMP) tcmp <= WriteDataM;
            if (en && cycle == tcmp)
                match <= 1'b1;
            else if (mmio_wr && offset == OFF_TSTAT && WriteDataM[TSTAT_MATCH])
                match <= 1'b0;
            if (mmio_wr && offset == OFF_TSTAT) en <= WriteDataM[TSTAT_EN];
        end
    end

    always_comb begin
        tstat_rd              = '0;
        tstat_rd[TSTAT_MATCH] = match;
        tstat_rd[TSTAT_EN]    = en;
    end
    assign tcmp_rd = tcmp;
    assign irq     = match & en;
`else
    assign tcmp_rd  = '0;
    assign tstat_rd = '0;
    assign irq      = 1'b0;
`endif

    assign fifo_push = mmio_wr && (offset == OFF_TXDATA);
    assign fifo_pop  = tx_valid && tx_ready;
    assign tx_valid  = !fifo_empty;

    arm_tx_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset_n(reset_n),
        .push   (fifo_push),
        .din    (WriteDataM[7:0]),
        .pop    (fifo_pop),
        .dout   (tx_data),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            ovf <= 1'b0;
        else if (fifo_push && fifo_full && !fifo_pop)
            ovf <= 1'b1;
        else if (mmio_wr && offset == OFF_TXSTAT && WriteDataM[TXSTAT_OVF])
            ovf <= 1'b0;
    end

    always_comb begin
        txstat               = '0;
        txstat[TXSTAT_FULL]  = fifo_full;
        txstat[TXSTAT_EMPTY] = fifo_empty;
        txstat[TXSTAT_OVF]   = ovf;
        txstat[15:8]         = 8'(fifo_count);
    end

    always_comb begin
        ReadDataM = '0;
        case (region)
            REG_RAM: ReadDataM = ram[ram_idx];
            REG_MMIO: begin
                case (offset)
                    OFF_CYCLE:  ReadDataM = cycle;
                    OFF_TCMP:   ReadDataM = tcmp_rd;
                    OFF_TSTAT:  ReadDataM = tstat_rd;
                    OFF_TXSTAT: ReadDataM = txstat;
                    default:    ReadDataM = '0;
                endcase
            end
            default: ReadDataM = '0;
        endcase
    end

endmodule

// File: tb/tb_arm_dmem_responder.sv
// Directed bench for arm_dmem_responder: vector table for single accesses plus
// sequences for the counter, timer, FIFO and reset behaviour.
module tb_arm_dmem_responder;

    localparam logic [31:0] A_CYCLE  = 32'hFFFF_0000;
    localparam logic [31:0] A_TCMP   = 32'hFFFF_0004;
    localparam logic [31:0] A_TSTAT  = 32'hFFFF_0008;
    localparam logic [31:0] A_TXDATA = 32'hFFFF_000C;
    localparam logic [31:0] A_TXSTAT = 32'hFFFF_0010;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        MemWriteM;
    logic [31:0] ALUOutM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;

    arm_dmem_responder dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .MemWriteM (MemWriteM),
        .ALUOutM   (ALUOutM),
        .WriteDataM(WriteDataM),
        .ReadDataM (ReadDataM),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        MemWriteM = 1'b0;
        ALUOutM   = a;
        #1 d = ReadDataM;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        MemWriteM  = 1'b1;
        ALUOutM    = a;
        WriteDataM = d;
        @(posedge clk);
        #1 MemWriteM = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d, c1, c2, tcmp_v;

        vecs[0]  = '{1'b1, 32'h0000_0010, 32'h1234_5678, 32'h0};
        vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         32'h1234_5678};
        vecs[2]  = '{1'b0, 32'h0000_0013, 32'h0,         32'h1234_5678};
        vecs[3]  = '{1'b1, 32'h0000_00FC, 32'hDEAD_BEEF, 32'h0};
        vecs[4]  = '{1'b0, 32'h0000_00FC, 32'h0,         32'hDEAD_BEEF};
        vecs[5]  = '{1'b1, 32'h0000_0000, 32'h0000_AAAA, 32'h0};
        vecs[6]  = '{1'b1, 32'h0000_0100, 32'h0000_BBBB, 32'h0};
        vecs[7]  = '{1'b0, 32'h0000_0000, 32'h0,         32'h0000_AAAA};
        vecs[8]  = '{1'b0, 32'h0000_0100, 32'h0,         32'h0};
        vecs[9]  = '{1'b0, 32'h4000_0000, 32'h0,         32'h0};
        vecs[10] = '{1'b0, A_TXDATA,      32'h0,         32'h0};
        vecs[11] = '{1'b0, A_TXSTAT,      32'h0,         32'h0000_0002};
        vecs[12] = '{1'b0, 32'hFFFF_0020, 32'h0,         32'h0};
        vecs[13] = '{1'b0, 32'hFFFE_0010, 32'h0,         32'h0};
        vecs[14] = '{1'b0, 32'hFFFF_0110, 32'h0,         32'h0000_0002};

        reset_n    = 1'b0;
        MemWriteM  = 1'b0;
        ALUOutM    = A_CYCLE;
        WriteDataM = '0;
        tx_ready   = 1'b0;

        #1;
        check("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
        check("rst_tx_data", {24'b0, tx_data}, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        rd(A_TXSTAT, d);
        check("rst_txstat", d, 32'h0000_0002);
        rd(A_CYCLE, d);
        check("rst_cycle", d, 32'h0);

        @(negedge clk);
        reset_n = 1'b1;
        ALUOutM = A_CYCLE;
        #1 check("cycle_at_release", ReadDataM, 32'h0);
        repeat (4) @(negedge clk);
        rd(A_CYCLE, d);
        check("cycle_after_5", d, 32'd5);

        for (int i = 0; i < 15; i++) begin
            if (vecs[i].we) wr(vecs[i].addr, vecs[i].wdata);
            else begin
                rd(vecs[i].addr, d);
                check($sformatf("vec%0d", i), d, vecs[i].exp);
            end
        end

        rd(A_CYCLE, c1);
        repeat (4) @(negedge clk);
        rd(A_CYCLE, c2);
        check("cycle_diff5", c2 - c1, 32'd5);
        rd(A_CYCLE, c1);
        wr(A_CYCLE, 32'h5);
        rd(A_CYCLE, c2);
        check("cycle_write_ignored", c2, c1 + 32'd2);

`ifdef ARM_DMEM_TIMER_EN
        rd(A_CYCLE, c1);
        tcmp_v = c1 + 32'd8;
        wr(A_TCMP, tcmp_v);
        wr(A_TSTAT, 32'h2);
        rd(A_TCMP, d);
        check("tcmp_rb", d, tcmp_v);
        for (int i = 0; i < 12; i++) begin
            rd(A_CYCLE, d);
            check($sformatf("irq_poll%0d", i), {31'b0, irq}, {31'b0, (d > tcmp_v + 32'd0)});
        end
        rd(A_TSTAT, d);
        check("tstat_match", d, 32'h3);
        wr(A_TSTAT, 32'h3);
        rd(A_TSTAT, d);
        check("tstat_w1c", d, 32'h2);
        check("irq_cleared", {31'b0, irq}, 32'h0);
        rd(A_CYCLE, c1);
        wr(A_TCMP, c1 + 32'd3);
        wr(A_TSTAT, 32'h3);
        wr(A_TSTAT, 32'h3);
        rd(A_TSTAT, d);
        check("set_beats_clear", d, 32'h3);
        check("irq_set_wins", {31'b0, irq}, 32'h1);
        wr(A_TSTAT, 32'h0);
        rd(A_TSTAT, d);
        check("tstat_en_off", d, 32'h1);
        check("irq_masked", {31'b0, irq}, 32'h0);
`else
        rd(A_CYCLE, c1);
        tcmp_v = c1 + 32'd3;
        wr(A_TCMP, tcmp_v);
        wr(A_TSTAT, 32'h2);
        rd(A_TCMP, d);
        check("tcmp_absent", d, 32'h0);
        repeat (6) @(negedge clk);
        rd(A_TSTAT, d);
        check("tstat_absent", d, 32'h0);
        check("irq_absent", {31'b0, irq}, 32'h0);
`endif

        // Overflow: nine pushes into eight slots with the sink stalled.
        for (int i = 0; i < 9; i++) wr(A_TXDATA, 32'hFFFF_FFA1 + i);
        rd(A_TXSTAT, d);
        check("ovf_txstat", d, 32'h0000_0805);
        check("ovf_head", {24'b0, tx_data}, 32'hA1);
        @(negedge clk);
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            check($sformatf("drain_valid%0d", i), {31'b0, tx_valid}, 32'h1);
            check($sformatf("drain_data%0d", i), {24'b0, tx_data}, 32'hA1 + i);
            @(negedge clk);
        end
        #1 check("drain_empty_valid", {31'b0, tx_valid}, 32'h0);
        tx_ready = 1'b0;
        rd(A_TXSTAT, d);
        check("drain_txstat", d, 32'h0000_0006);
        wr(A_TXSTAT, 32'h4);
        rd(A_TXSTAT, d);
        check("ovf_w1c", d, 32'h0000_0002);

        // Push into a full FIFO while the head is popped on the same edge.
        for (int i = 0; i < 8; i++) wr(A_TXDATA, 32'hB1 + i);
        rd(A_TXSTAT, d);
        check("full_txstat", d, 32'h0000_0801);
        @(negedge clk);
        tx_ready   = 1'b1;
        MemWriteM  = 1'b1;
        ALUOutM    = A_TXDATA;
        WriteDataM = 32'hB9;
        @(posedge clk);
        #1;
        MemWriteM = 1'b0;
        tx_ready  = 1'b0;
        rd(A_TXSTAT, d);
        check("pushpop_txstat", d, 32'h0000_0801);
        @(negedge clk);
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1 check($sformatf("pp_data%0d", i), {24'b0, tx_data}, 32'hB2 + i);
            @(negedge clk);
        end
        #1 check("pp_empty", {31'b0, tx_valid}, 32'h0);
        tx_ready = 1'b0;

        // Asynchronous reset with bytes still queued.
        for (int i = 0; i < 3; i++) wr(A_TXDATA, 32'hC1 + i);
        rd(A_TXSTAT, d);
        check("three_txstat", d, 32'h0000_0300);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("async_tx_valid", {31'b0, tx_valid}, 32'h0);
        check("async_tx_data", {24'b0, tx_data}, 32'h0);
        check("async_irq", {31'b0, irq}, 32'h0);
        rd(A_TXSTAT, d);
        check("async_txstat", d, 32'h0000_0002);
        rd(32'h4000_0000, d);
        check("async_unmapped", d, 32'h0);
        rd(32'h0000_0010, d);
        check("ram_kept", d, 32'h1234_5678);
        rd(A_CYCLE, d);
        check("async_cycle", d, 32'h0);
        reset_n = 1'b1;

        // Counter wrap, starting from a value placed just below the top.
        @(negedge clk);
        force dut.cycle = 32'hFFFF_FFFE;
        #1 release dut.cycle;
        rd(A_CYCLE, d);
        check("wrap_ffffffff", d, 32'hFFFF_FFFF);
        rd(A_CYCLE, d);
        check("wrap_zero", d, 32'h0);
        rd(A_CYCLE, d);
        check("wrap_one", d, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
